// File: rtl/fetch_stage_pkg.sv
// Shared constants, state encoding and payload types for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

    typedef enum logic [1:0] {
        FS_REQ     = 2'd0,
        FS_HOLD    = 2'd1,
        FS_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } hold_entry_t;

    // Branch targets are word addresses; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding buffer for a fetched word that decode could not take.
module fetch_hold_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  hold_entry_t din,
    output logic        valid,
    output hold_entry_t dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ready handshake, back-pressure buffer and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n, pend_pc, pend_pc_n, imem_addr_n;
    logic [31:0]  id_inst_n, id_pc_n, id_pc_plus4_n;
    logic         id_valid_n, imem_req_n;
    logic         resp, hb_valid, hb_load, hb_clear;
    hold_entry_t  hb_din, hb_dout;

    assign resp   = imem_req && imem_ready;
    assign hb_din = '{inst: imem_rdata, pc: pc};

    fetch_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (hb_load),
        .clear (hb_clear),
        .din   (hb_din),
        .valid (hb_valid),
        .dout  (hb_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FS_REQ;
            pc          <= RESET_PC;
            pend_pc     <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            id_inst     <= NOP_INST;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pend_pc     <= pend_pc_n;
            imem_req    <= imem_req_n;
            imem_addr   <= imem_addr_n;
            id_inst     <= id_inst_n;
            id_pc       <= id_pc_n;
            id_pc_plus4 <= id_pc_plus4_n;
            id_valid    <= id_valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        pend_pc_n     = pend_pc;
        id_inst_n     = id_inst;
        id_pc_n       = id_pc;
        id_pc_plus4_n = id_pc_plus4;
        id_valid_n    = id_valid;
        hb_load       = 1'b0;
        hb_clear      = 1'b0;

        if (redirect) begin
            id_inst_n  = NOP_INST;
            id_valid_n = 1'b0;
            hb_clear   = 1'b1;
            // An unanswered request must complete before the new target is fetched.
            if (imem_req && !imem_ready) begin
                pend_pc_n = align_pc(redirect_pc);
                state_n   = FS_DISCARD;
            end else begin
                pc_n    = align_pc(redirect_pc);
                state_n = FS_REQ;
            end
        end else begin
            unique case (state)
                FS_REQ: begin
                    if (flush) begin
                        id_inst_n  = NOP_INST;
                        id_valid_n = 1'b0;
                    end else if (resp) begin
                        pc_n = pc + PC_STEP;
                        if (!stall && !hb_valid) begin
                            id_inst_n     = imem_rdata;
                            id_pc_n       = pc;
                            id_pc_plus4_n = pc + PC_STEP;
                            id_valid_n    = 1'b1;
                        end else begin
                            hb_load = 1'b1;
                            state_n = FS_HOLD;
                        end
                    end else if (!stall) begin
                        id_inst_n  = NOP_INST;
                        id_valid_n = 1'b0;
                    end
                end
                FS_HOLD: begin
                    if (flush) begin
                        id_inst_n  = NOP_INST;
                        id_valid_n = 1'b0;
                        hb_clear   = 1'b1;
                        state_n    = FS_REQ;
                    end else if (!stall) begin
                        id_inst_n     = hb_dout.inst;
                        id_pc_n       = hb_dout.pc;
                        id_pc_plus4_n = hb_dout.pc + PC_STEP;
                        id_valid_n    = 1'b1;
                        hb_clear      = 1'b1;
                        state_n       = FS_REQ;
                    end
                end
                FS_DISCARD: begin
                    if (resp) begin
                        pc_n    = pend_pc;
                        state_n = FS_REQ;
                    end
                    if (flush || !stall) begin
                        id_inst_n  = NOP_INST;
                        id_valid_n = 1'b0;
                    end
                end
                default: state_n = FS_REQ;
            endcase
        end

        imem_req_n  = (state_n != FS_HOLD);
        imem_addr_n = pc_n;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs a queue-based model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, redirect, imem_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_inst, id_pc, id_pc_plus4;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;

    logic        m_req, m_valid;
    logic [31:0] m_pc, m_addr, m_inst, m_id_pc, m_id_pc4;
    logic [31:0] m_pend[$];
    entry_t      m_buf[$];

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .id_inst(id_inst),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    // Reference: pending redirect targets and buffered words kept as queues.
    task automatic model_update();
        logic resp, dropped;
        logic [31:0] tgt;
        resp    = m_req && imem_ready;
        dropped = 1'b0;
        tgt     = {redirect_pc[31:2], 2'b00};
        if (rst) begin
            m_pc = 32'h0; m_req = 1'b0; m_addr = 32'h0;
            m_pend.delete(); m_buf.delete();
            m_inst = NOP; m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            if (redirect) begin
                m_inst = NOP; m_valid = 1'b0; m_buf.delete();
                m_pend.delete();
                if (m_req && !imem_ready) m_pend.push_back(tgt);
                else m_pc = tgt;
            end else begin
                if (resp && m_pend.size() > 0) begin
                    m_pc = m_pend.pop_front();
                    dropped = 1'b1;
                end
                if (flush) begin
                    m_inst = NOP; m_valid = 1'b0; m_buf.delete();
                end else if (m_buf.size() > 0) begin
                    if (!stall) begin
                        m_inst = m_buf[0].inst; m_id_pc = m_buf[0].pc;
                        m_id_pc4 = m_buf[0].pc + 32'd4; m_valid = 1'b1;
                        m_buf.delete();
                    end
                end else if (resp && !dropped) begin
                    if (stall) m_buf.push_back('{imem_rdata, m_pc});
                    else begin
                        m_inst = imem_rdata; m_id_pc = m_pc;
                        m_id_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                    end
                    m_pc = m_pc + 32'd4;
                end else if (!stall) begin
                    m_inst = NOP; m_valid = 1'b0;
                end
            end
            m_req  = (m_buf.size() == 0);
            m_addr = m_pc;
        end
    endtask

    task automatic step(input logic r, input logic st, input logic fl, input logic rd,
                        input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata);
        rst = r; stall = st; flush = fl; redirect = rd;
        redirect_pc = rpc; imem_ready = rdy; imem_rdata = rdata;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %0h exp 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        vectors++; if (id_inst !== NOP) begin miscompares++; $display("FAIL reset_inst got %h exp %h", id_inst, NOP); end
        vectors++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h/%h exp 0/0", id_pc, id_pc_plus4); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0h exp 0", id_valid); end
    endtask

    task automatic test_zero_wait();
        step(0, 0, 0, 0, 0, 1, 32'h0050_0093);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL zw_first_req got %0h@%h exp 1@0", imem_req, imem_addr); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL zw_valid_early got %0h exp 0", id_valid); end
        step(0, 0, 0, 0, 0, 1, 32'h0050_0093);
        vectors++; if (id_valid !== 1'b1 || id_inst !== 32'h0050_0093) begin miscompares++; $display("FAIL zw_first_inst got %0h/%h exp 1/00500093", id_valid, id_inst); end
        vectors++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL zw_first_pc got %h/%h exp 0/4", id_pc, id_pc_plus4); end
        vectors++; if (imem_addr !== 32'h4) begin miscompares++; $display("FAIL zw_addr4 got %h exp 4", imem_addr); end
        step(0, 0, 0, 0, 0, 1, 32'h0050_0093);
        vectors++; if (imem_addr !== 32'h8 || id_pc !== 32'h4) begin miscompares++; $display("FAIL zw_addr8 got %h/%h exp 8/4", imem_addr, id_pc); end
    endtask

    task automatic test_stall();
        step(0, 0, 0, 0, 0, 1, 32'h1111_0008);
        step(0, 0, 0, 0, 0, 1, 32'h1111_000C);
        vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL st_addr got %h exp 10", imem_addr); end
        step(0, 1, 0, 0, 0, 1, 32'hAAAA_0010);
        for (int i = 0; i < 2; i++) begin
            vectors++; if (imem_req !== 1'b0 || id_pc !== 32'hC) begin miscompares++; $display("FAIL st_hold%0d got req=%0h pc=%h exp 0/c", i, imem_req, id_pc); end
            step(0, 1, 0, 0, 0, 1, 32'hBAD0_BAD0);
        end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL st_hold2 got req=%0h exp 0", imem_req); end
        step(0, 0, 0, 0, 0, 0, 32'hBAD0_BAD0);
        vectors++; if (id_pc !== 32'h10 || id_inst !== 32'hAAAA_0010 || id_valid !== 1'b1) begin miscompares++; $display("FAIL st_release got %h/%h/%0h exp 10/aaaa0010/1", id_pc, id_inst, id_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin miscompares++; $display("FAIL st_rereq got %0h@%h exp 1@14", imem_req, imem_addr); end
        step(0, 0, 0, 0, 0, 1, 32'hAAAA_0014);
        vectors++; if (id_pc !== 32'h14 || id_inst !== 32'hAAAA_0014) begin miscompares++; $display("FAIL st_next got %h/%h exp 14/aaaa0014", id_pc, id_inst); end
    endtask

    task automatic test_redirect_pending();
        step(0, 0, 0, 1, 32'h40, 1, 32'h0);
        vectors++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin miscompares++; $display("FAIL rp_setup got %0h@%h exp 1@40", imem_req, imem_addr); end
        step(0, 0, 0, 1, 32'h200, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            vectors++; if (imem_addr !== 32'h40 || imem_req !== 1'b1 || id_valid !== 1'b0) begin miscompares++; $display("FAIL rp_wait%0d got %0h@%h v=%0h exp 1@40 v=0", i, imem_req, imem_addr, id_valid); end
            step(0, 0, 0, 0, 0, (i == 1), 32'hD00D_0040);
        end
        vectors++; if (imem_addr !== 32'h200 || id_valid !== 1'b0) begin miscompares++; $display("FAIL rp_drop got %h v=%0h exp 200 v=0", imem_addr, id_valid); end
        step(0, 0, 0, 0, 0, 1, 32'hC0DE_0200);
        vectors++; if (id_pc !== 32'h200 || id_inst !== 32'hC0DE_0200 || id_valid !== 1'b1) begin miscompares++; $display("FAIL rp_target got %h/%h/%0h exp 200/c0de0200/1", id_pc, id_inst, id_valid); end
    endtask

    task automatic test_flush_stall_redirect();
        step(0, 1, 1, 1, 32'h103, 1, 32'hFFFF_FFFF);
        vectors++; if (id_inst !== NOP || id_valid !== 1'b0) begin miscompares++; $display("FAIL fsr_squash got %h/%0h exp 00000013/0", id_inst, id_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL fsr_target got %0h@%h exp 1@100", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0);
        step(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        vectors++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc got %h/%h exp fffffffc/0", id_pc, id_pc_plus4); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_reset_discard();
        step(0, 0, 0, 1, 32'h300, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 32'h0);
        vectors++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rd_reset got %0h@%h v=%0h exp 0@0 v=0", imem_req, imem_addr, id_valid); end
        step(0, 0, 0, 0, 0, 0, 32'h0);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rd_resume got %0h@%h exp 1@0", imem_req, imem_addr); end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int i = 0; i < 600; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0), rpc, ($urandom_range(0, 1) == 1), $urandom);
            vectors++; if (imem_req !== m_req) begin miscompares++; $display("FAIL rnd_req cyc %0d got %0h exp %0h", i, imem_req, m_req); end
            vectors++; if (imem_addr !== m_addr) begin miscompares++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, imem_addr, m_addr); end
            vectors++; if (id_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid cyc %0d got %0h exp %0h", i, id_valid, m_valid); end
            vectors++; if (id_inst !== m_inst) begin miscompares++; $display("FAIL rnd_inst cyc %0d got %h exp %h", i, id_inst, m_inst); end
            if (m_valid) begin
                vectors++; if (id_pc !== m_id_pc || id_pc_plus4 !== m_id_pc4) begin miscompares++; $display("FAIL rnd_pc cyc %0d got %h/%h exp %h/%h", i, id_pc, id_pc_plus4, m_id_pc, m_id_pc4); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_pending();
        test_flush_stall_redirect();
        test_wrap();
        test_reset_discard();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch unit with the IF/ID pipeline register.
- Owns the PC and runs a req/ready handshake with instruction memory.
- Absorbs back-pressure through a one-entry holding buffer.
- Presents the fetched instruction and its PC to decode, where the immediate generator, register file and control unit consume them.
- Handles branch/jump redirects, including redirects that arrive while a memory request is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold the IF/ID register.
- flush  in  1  squash the IF/ID register and the holding buffer.
- redirect  in  1  taken branch/jump/jalr resolved; fetch from redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  memory response valid this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- id_inst  out  32  IF/ID instruction.
- id_pc  out  32  IF/ID PC.
- id_pc_plus4  out  32  id_pc+4, modulo 2^32.
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=S_REQ, buffer empty.
  - imem_req=0, imem_addr=RESET_PC.
  - id_inst=NOP_INST, id_pc=0, id_pc_plus4=0, id_valid=0.
  - Reset mid-transaction abandons any in-flight response; memory must tolerate this.
- First request: the cycle after rst deasserts, imem_req=1 with imem_addr=RESET_PC.
- Handshake rules:
  - Once imem_req=1, imem_req and imem_addr hold stable until a cycle with imem_ready=1.
  - A response is accepted in the same cycle as imem_ready; ready without req is ignored.
  - Zero-wait memory (ready tied 1) sustains one instruction per cycle.
  - Latency from ready to id_inst is one edge.
- States:
  - S_REQ: request outstanding at pc. On ready with no redirect/flush:
    - if the IF/ID register can accept (stall=0 and buffer empty): IF/ID <= {rdata, pc, pc+4}, id_valid=1, pc<=pc+4, stay in S_REQ.
    - if stall=1: the word goes into the buffer, pc<=pc+4, go to S_HOLD.
  - S_HOLD: buffer full, imem_req=0. When stall=0: IF/ID <= buffer, buffer cleared, go to S_REQ; the new request issues the next cycle.
  - S_DISCARD: entered when redirect=1 in S_REQ without ready that cycle. Target latched into pend_pc, imem_addr stays at the old pc. On ready the data is dropped, pc<=pend_pc, go to S_REQ. A further redirect while here overwrites pend_pc.
- Redirect:
  - Redirect with no outstanding request, or coinciding with ready, drops that response; pc<=redirect_pc and the state goes to S_REQ.
  - Redirect implies flush.
- Flush (or redirect):
  - id_inst<=NOP_INST, id_valid<=0, buffer cleared.
  - id_pc and id_pc_plus4 may hold stale values.
  - Flush without redirect does not change pc or an outstanding request.
  - flush overrides stall: IF/ID is squashed even when stall=1.
  - A flush from S_HOLD returns to S_REQ at the current pc; the buffered word is lost.
- Stall with no incoming data: IF/ID holds all fields unchanged.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no flag is raised.
- Priority: rst > redirect > flush > stall > normal advance.

Decomposition:
- defines.v gets:
  - `NOP_INST;
  - fetch state encodings `FS_REQ, `FS_HOLD, `FS_DISCARD (2-bit);
  - `PC_STEP=4.
- One sub-module, fetch_hold_buf: a one-entry {inst, pc} register with load/clear/valid. Top level holds the PC, the FSM and the IF/ID register. Target size is about 200 lines.

Test Plan:
- Reset then zero-wait memory (ready=1, rdata=0x00500093):
  - imem_addr goes 0x0, 0x4, 0x8 on consecutive cycles.
  - id_valid=1 two edges after rst falls.
  - id_pc=0x0 and id_pc_plus4=0x4 on the first instruction.
- Stall for 3 cycles with ready=1 while fetching 0x10:
  - the word for 0x10 is buffered and imem_req=0 during the stall.
  - after stall drops, id_pc=0x10, then 0x14; no instruction is lost or duplicated.
- Redirect to 0x200 while a request at 0x40 is pending (ready=0 for 2 cycles):
  - imem_addr stays 0x40 until ready.
  - the 0x40 data is dropped and the next request is 0x200.
  - id_valid=0 until 0x200 returns.
- redirect_pc=0x103 with flush=1 and stall=1 together:
  - id_inst=0x00000013, id_valid=0.
  - the next request is at 0x100.
- PC at 0xFFFF_FFFC, ready=1: id_pc_plus4=0x0 and the next imem_addr is 0x0.
- rst asserted in S_DISCARD: the next edge gives imem_req=0 and id_valid=0, then fetch resumes at RESET_PC.
